// File: rtl/riscv_defines.sv
// Shared definitions for the instruction-port arbiter:
// FSM state encoding and requester index constants.
package riscv_defines;

   typedef enum logic {
      ARB_FREE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   localparam logic ARB_IF  = 1'b0;
   localparam logic ARB_SEC = 1'b1;

   localparam int unsigned ARB_ADDR_W = 32;

endpackage

// File: rtl/riscv_instr_arb_fifo.sv
// Owner FIFO: remembers which requester owns each in-flight
// transaction so responses are routed back in order.
module riscv_instr_arb_fifo #(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic din,
   input  logic pop,
   output logic full,
   output logic empty,
   output logic head
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);

   logic [DEPTH-1:0] mem_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW-1:0]    wr_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count_q == CNT_MAX);
   assign empty   = (count_q == '0);
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Storage and pointers; pointers wrap modulo DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
      end
   end

   // Occupancy count; simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/riscv_instr_arbiter.sv
// Two-requester arbiter for the instruction memory port with
// round-robin selection, address-phase locking and in-order responses.
module riscv_instr_arbiter
   import riscv_defines::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned RDATA_WIDTH     = 32
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [1:0]                       req_i,
   input  logic [1:0][ARB_ADDR_W-1:0]       addr_i,
   output logic [1:0]                       gnt_o,
   output logic [1:0]                       rvalid_o,
   output logic [RDATA_WIDTH-1:0]           rdata_o,
   output logic [1:0]                       err_pmp_o,
   output logic                             instr_req_o,
   output logic [ARB_ADDR_W-1:0]            instr_addr_o,
   input  logic                             instr_gnt_i,
   input  logic                             instr_rvalid_i,
   input  logic [RDATA_WIDTH-1:0]           instr_rdata_i,
   input  logic                             instr_err_pmp_i,
   output logic                             busy_o
);

   arb_state_e state_q;
   arb_state_e state_d;
   logic       sel_q;
   logic       rr_last_q;
   logic       winner;
   logic       push;
   logic       fifo_full;
   logic       fifo_empty;
   logic       fifo_head;

   assign push = instr_req_o & instr_gnt_i;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_FREE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: lock on an ungranted request, unlock on grant or drop.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB_FREE: begin
            if (instr_req_o && !instr_gnt_i) begin
               state_d = ARB_LOCKED;
            end
         end
         ARB_LOCKED: begin
            if (push || !req_i[sel_q]) begin
               state_d = ARB_FREE;
            end
         end
         default: state_d = ARB_FREE;
      endcase
   end

   // Outputs: winner selection, memory request and response routing.
   always_comb begin
      winner    = ARB_IF;
      gnt_o     = '0;
      rvalid_o  = '0;
      err_pmp_o = '0;
      priority case (1'b1)
         state_q == ARB_LOCKED: winner = sel_q;
         &req_i:                winner = ~rr_last_q;
         req_i[ARB_SEC]:        winner = ARB_SEC;
         default:               winner = ARB_IF;
      endcase
      instr_req_o       = rst_n & req_i[winner] & ~fifo_full;
      instr_addr_o      = addr_i[winner];
      gnt_o[winner]     = instr_gnt_i & instr_req_o;
      rvalid_o[fifo_head]  = rst_n & instr_rvalid_i & ~fifo_empty;
      err_pmp_o[fifo_head] = rst_n & instr_rvalid_i & ~fifo_empty
                             & instr_err_pmp_i;
      rdata_o           = instr_rdata_i;
      busy_o            = rst_n & (~fifo_empty | (|req_i));
   end

   // Selection hold and round-robin history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q     <= ARB_IF;
         rr_last_q <= ARB_SEC;
      end else begin
         if (state_q == ARB_FREE && state_d == ARB_LOCKED) begin
            sel_q <= winner;
         end
         if (push) begin
            rr_last_q <= winner;
         end
      end
   end

   riscv_instr_arb_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_owner_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (winner),
      .pop   (instr_rvalid_i),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   // Protocol checks on the memory and requester sides.
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!(instr_gnt_i && !instr_req_o))
            else $warning("arbiter: grant without request");
         assert (!(instr_rvalid_i && fifo_empty))
            else $warning("arbiter: rvalid with no outstanding entry");
         assert (!(state_q == ARB_LOCKED && !req_i[sel_q]))
            else $warning("arbiter: locked requester dropped req");
      end
   end

endmodule

// File: tb/tb_riscv_instr_arbiter.sv
// Self-checking bench for riscv_instr_arbiter: directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_riscv_instr_arbiter;

   localparam int unsigned MAXO = 2;
   localparam int unsigned RW   = 32;

   logic              clk;
   logic              rst_n;
   logic [1:0]        req_i;
   logic [1:0][31:0]  addr_i;
   logic [1:0]        gnt_o;
   logic [1:0]        rvalid_o;
   logic [RW-1:0]     rdata_o;
   logic [1:0]        err_pmp_o;
   logic              instr_req_o;
   logic [31:0]       instr_addr_o;
   logic              instr_gnt_i;
   logic              instr_rvalid_i;
   logic [RW-1:0]     instr_rdata_i;
   logic              instr_err_pmp_i;
   logic              busy_o;

   int n_tests;
   int n_fail;

   riscv_instr_arbiter #(
      .MAX_OUTSTANDING (MAXO),
      .RDATA_WIDTH     (RW)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_i           (req_i),
      .addr_i          (addr_i),
      .gnt_o           (gnt_o),
      .rvalid_o        (rvalid_o),
      .rdata_o         (rdata_o),
      .err_pmp_o       (err_pmp_o),
      .instr_req_o     (instr_req_o),
      .instr_addr_o    (instr_addr_o),
      .instr_gnt_i     (instr_gnt_i),
      .instr_rvalid_i  (instr_rvalid_i),
      .instr_rdata_i   (instr_rdata_i),
      .instr_err_pmp_i (instr_err_pmp_i),
      .busy_o          (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      req_i           = 2'b00;
      addr_i[0]       = 32'h0;
      addr_i[1]       = 32'h0;
      instr_gnt_i     = 1'b0;
      instr_rvalid_i  = 1'b0;
      instr_rdata_i   = '0;
      instr_err_pmp_i = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n          = 1'b0;
      req_i          = 2'b11;
      instr_gnt_i    = 1'b1;
      instr_rvalid_i = 1'b1;
      #1;
      n_tests++;
      if (instr_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_req got %b exp 0", instr_req_o);
      end
      n_tests++;
      if ({gnt_o, rvalid_o, err_pmp_o} !== 6'b0) begin
         n_fail++;
         $display("FAIL rst_outs got %b exp 0", {gnt_o, rvalid_o, err_pmp_o});
      end
      n_tests++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_busy got %b exp 0", busy_o);
      end
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g [6];
      logic [1:0] exp_v [6];
      exp_g = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01};
      exp_v = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
      do_reset();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         req_i          = 2'b11;
         instr_gnt_i    = 1'b1;
         instr_rvalid_i = (c >= 2);
         #1;
         n_tests++;
         if (gnt_o !== exp_g[c]) begin
            n_fail++;
            $display("FAIL rr_gnt c%0d got %b exp %b", c, gnt_o, exp_g[c]);
         end
         n_tests++;
         if (rvalid_o !== exp_v[c]) begin
            n_fail++;
            $display("FAIL rr_rvalid c%0d got %b exp %b", c, rvalid_o, exp_v[c]);
         end
      end
   endtask

   task automatic test_lock();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         req_i       = (c == 0) ? 2'b01 : 2'b11;
         addr_i[0]   = 32'h100;
         addr_i[1]   = 32'h200;
         instr_gnt_i = (c == 3);
         #1;
         n_tests++;
         if (instr_addr_o !== 32'h100 || instr_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_addr c%0d got %h/%b exp 100/1",
                     c, instr_addr_o, instr_req_o);
         end
         n_tests++;
         if (gnt_o !== ((c == 3) ? 2'b01 : 2'b00)) begin
            n_fail++;
            $display("FAIL lock_gnt c%0d got %b", c, gnt_o);
         end
      end
      @(negedge clk);
      req_i       = 2'b11;
      instr_gnt_i = 1'b0;
      #1;
      n_tests++;
      if (instr_addr_o !== 32'h200) begin
         n_fail++;
         $display("FAIL lock_next got %h exp 200", instr_addr_o);
      end
   endtask

   task automatic test_full();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         req_i          = 2'b01;
         instr_gnt_i    = (c != 2);
         instr_rvalid_i = (c == 2);
         if (c == 2) instr_gnt_i = 1'b0;
         #1;
         n_tests++;
         if (instr_req_o !== (c != 2)) begin
            n_fail++;
            $display("FAIL full_req c%0d got %b exp %b",
                     c, instr_req_o, (c != 2));
         end
      end
   endtask

   task automatic test_order();
      do_reset();
      @(negedge clk);
      req_i       = 2'b10;
      instr_gnt_i = 1'b1;
      @(negedge clk);
      req_i       = 2'b01;
      #1;
      n_tests++;
      if (gnt_o !== 2'b01) begin
         n_fail++;
         $display("FAIL ord_gnt got %b exp 01", gnt_o);
      end
      @(negedge clk);
      req_i          = 2'b00;
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = 32'hAAAA0001;
      #1;
      n_tests++;
      if (rvalid_o !== 2'b10 || rdata_o !== 32'hAAAA0001) begin
         n_fail++;
         $display("FAIL ord_r1 got %b/%h exp 10/AAAA0001", rvalid_o, rdata_o);
      end
      @(negedge clk);
      instr_rdata_i = 32'hBBBB0002;
      #1;
      n_tests++;
      if (rvalid_o !== 2'b01 || rdata_o !== 32'hBBBB0002) begin
         n_fail++;
         $display("FAIL ord_r2 got %b/%h exp 01/BBBB0002", rvalid_o, rdata_o);
      end
      @(negedge clk);
      instr_rvalid_i = 1'b0;
      #1;
      n_tests++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ord_busy got %b exp 0", busy_o);
      end
   endtask

   task automatic test_err();
      do_reset();
      @(negedge clk);
      req_i       = 2'b10;
      instr_gnt_i = 1'b1;
      @(negedge clk);
      idle_inputs();
      instr_rvalid_i  = 1'b1;
      instr_err_pmp_i = 1'b1;
      #1;
      n_tests++;
      if (err_pmp_o !== 2'b10 || rvalid_o !== 2'b10) begin
         n_fail++;
         $display("FAIL err_pmp got %b/%b exp 10/10", err_pmp_o, rvalid_o);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         req_i       = 2'b01;
         instr_gnt_i = 1'b1;
      end
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      #1;
      n_tests++;
      if (busy_o !== 1'b0 || instr_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_rst got %b/%b exp 0/0", busy_o, instr_req_o);
      end
      @(negedge clk);
      rst_n          = 1'b1;
      instr_rvalid_i = 1'b1;
      #1;
      n_tests++;
      if (rvalid_o !== 2'b00 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_spur got %b/%b exp 00/0", rvalid_o, busy_o);
      end
      @(negedge clk);
      instr_rvalid_i = 1'b0;
      req_i          = 2'b01;
      instr_gnt_i    = 1'b1;
      #1;
      n_tests++;
      if (instr_req_o !== 1'b1 || gnt_o !== 2'b01) begin
         n_fail++;
         $display("FAIL mid_after got %b/%b exp 1/01", instr_req_o, gnt_o);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_random();
      bit         mq[$];
      bit         m_last;
      bit         m_locked;
      bit         m_sel;
      bit         w;
      bit         e_req;
      logic [1:0] r;
      logic [1:0] e_gnt;
      logic [1:0] e_rv;
      logic [1:0] e_err;
      logic       e_busy;
      do_reset();
      mq.delete();
      m_last   = 1'b1;
      m_locked = 1'b0;
      m_sel    = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         r = 2'($urandom);
         if (m_locked) r[m_sel] = 1'b1;
         req_i     = r;
         addr_i[0] = $urandom;
         addr_i[1] = $urandom;
         if (m_locked)        w = m_sel;
         else if (r == 2'b11) w = ~m_last;
         else                 w = r[1];
         e_req = r[w] && (mq.size() < MAXO);
         instr_gnt_i     = e_req && ($urandom_range(0, 2) != 0);
         instr_rvalid_i  = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
         instr_err_pmp_i = 1'($urandom);
         instr_rdata_i   = $urandom;
         e_gnt  = (e_req && instr_gnt_i) ? (2'b01 << w) : 2'b00;
         e_rv   = instr_rvalid_i ? (2'b01 << mq[0]) : 2'b00;
         e_err  = instr_err_pmp_i ? e_rv : 2'b00;
         e_busy = (mq.size() > 0) || (r != 2'b00);
         #1;
         n_tests++;
         if (instr_req_o !== e_req) begin
            n_fail++;
            $display("FAIL rnd_req i%0d got %b exp %b", i, instr_req_o, e_req);
         end
         n_tests++;
         if (e_req && instr_addr_o !== addr_i[w]) begin
            n_fail++;
            $display("FAIL rnd_addr i%0d got %h exp %h", i, instr_addr_o, addr_i[w]);
         end
         n_tests++;
         if (gnt_o !== e_gnt) begin
            n_fail++;
            $display("FAIL rnd_gnt i%0d got %b exp %b", i, gnt_o, e_gnt);
         end
         n_tests++;
         if (rvalid_o !== e_rv || err_pmp_o !== e_err) begin
            n_fail++;
            $display("FAIL rnd_rsp i%0d got %b/%b exp %b/%b",
                     i, rvalid_o, err_pmp_o, e_rv, e_err);
         end
         n_tests++;
         if (rdata_o !== instr_rdata_i || busy_o !== e_busy) begin
            n_fail++;
            $display("FAIL rnd_data i%0d got %h/%b exp %h/%b",
                     i, rdata_o, busy_o, instr_rdata_i, e_busy);
         end
         @(posedge clk);
         if (instr_rvalid_i) void'(mq.pop_front());
         if (e_req && instr_gnt_i) begin
            mq.push_back(w);
            m_last   = w;
            m_locked = 1'b0;
         end else if (e_req) begin
            m_locked = 1'b1;
            m_sel    = w;
         end else begin
            m_locked = 1'b0;
         end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      idle_inputs();
      test_reset();
      test_round_robin();
      test_lock();
      test_full();
      test_order();
      test_err();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_instr_arbiter.md
RISCV_INSTR_ARBITER -- requirements
Module: riscv_instr_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2: maximum in-flight granted transactions, range 1..4.
REQ-002 SHALL have parameter RDATA_WIDTH, default 32: width of the instruction read data.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port req_i, input, 2: request per requester; bit 0 = IF prefetch, bit 1 = secondary (debug program buffer / L0 refill).
REQ-006 SHALL have port addr_i, input, 2x32: address per requester.
REQ-007 SHALL have port gnt_o, output, 2: grant per requester.
REQ-008 SHALL have port rvalid_o, output, 2: response valid per requester.
REQ-009 SHALL have port rdata_o, input-derived output, RDATA_WIDTH: response data, broadcast to both requesters.
REQ-010 SHALL have port err_pmp_o, output, 2: PMP fetch error per requester.
REQ-011 SHALL have ports instr_req_o (out, 1), instr_addr_o (out, 32), instr_gnt_i (in, 1), instr_rvalid_i (in, 1), instr_rdata_i (in, RDATA_WIDTH) and instr_err_pmp_i (in, 1): memory-side port.
REQ-012 SHALL have port busy_o, output, 1: high while any transaction is outstanding or a request is pending.

Function
REQ-013 SHALL implement a 2-state FSM: ARB_FREE (no pending unanswered address phase) and ARB_LOCKED (instr_req_o high, not yet granted).
REQ-014 In ARB_FREE, SHALL select the winner combinationally; one requester alone wins; with both requesting, the winner is the requester whose index differs from rr_last_q.
REQ-015 SHALL drive instr_req_o = req_i[winner] & ~fifo_full and instr_addr_o = addr_i[winner].
REQ-016 SHALL drive gnt_o[winner] = instr_gnt_i & instr_req_o, and gnt_o of the other requester = 0.
REQ-017 If instr_req_o = 1 and instr_gnt_i = 0, SHALL go to ARB_LOCKED and hold the selection in sel_q; the winner SHALL not change until the grant arrives.
REQ-018 In ARB_LOCKED, SHALL use sel_q as the winner and return to ARB_FREE in the cycle instr_gnt_i = 1.
REQ-019 If the locked requester deasserts req_i, SHALL return to ARB_FREE; this is a protocol violation and is covered by an assertion.
REQ-020 On every accepted grant (instr_req_o & instr_gnt_i), SHALL update rr_last_q to the winner and push the winner index into the owner FIFO.
REQ-021 The owner FIFO SHALL be MAX_OUTSTANDING deep and pop on instr_rvalid_i.
REQ-022 SHALL drive rvalid_o[head] = instr_rvalid_i and err_pmp_o[head] = instr_rvalid_i & instr_err_pmp_i.
REQ-023 SHALL drive rdata_o = instr_rdata_i with zero latency.
REQ-024 When the FIFO is full, SHALL force instr_req_o = 0 even if instr_rvalid_i = 1 in the same cycle; no full-pop bypass.
REQ-025 When the FIFO is not full, a same-cycle push and pop SHALL keep the count unchanged, with the new entry placed behind the head.
REQ-026 instr_rvalid_i with an empty FIFO SHALL drive no rvalid_o, leave state unchanged, and fire an assertion.
REQ-027 Read and write pointers SHALL wrap modulo MAX_OUTSTANDING; the count SHALL be $clog2(MAX_OUTSTANDING+1) bits wide.
REQ-028 SHALL assert that instr_gnt_i never arrives while instr_req_o = 0.

Reset
REQ-029 On rst_n low, SHALL asynchronously set FSM = ARB_FREE, sel_q = 0, rr_last_q = 1 (so the IF prefetch wins first), FIFO count and pointers = 0.
REQ-030 During reset, SHALL hold instr_req_o, gnt_o, rvalid_o, err_pmp_o and busy_o at 0.
REQ-031 Reset mid-transaction SHALL discard all outstanding entries; late instr_rvalid_i after reset falls under REQ-026.

Structure
REQ-032 SHALL place the FSM state enum (ARB_FREE, ARB_LOCKED) and the requester index constants (ARB_IF = 0, ARB_SEC = 1) in riscv_defines.
REQ-033 SHALL implement the owner FIFO as one sub-module, riscv_instr_arb_fifo (parameter DEPTH, 1-bit data, with push, pop, full, empty and head outputs).

Verification
REQ-034 Reset, then req_i = 2'b11 with instr_gnt_i = 1 -> the first grant goes to requester 0, the next to requester 1, and grants alternate 0,1,0,1.
REQ-035 req_i[0] = 1 at addr 0x100 with gnt held low 3 cycles while req_i[1] rises -> instr_addr_o stays 0x100 and the FSM stays ARB_LOCKED; on the 4th cycle gnt_o[0] = 1.
REQ-036 MAX_OUTSTANDING = 2, two grants with no rvalid -> instr_req_o = 0 in the 3rd cycle; one rvalid -> instr_req_o = 1 in the following cycle.
REQ-037 Grants in order 1,0, then rvalids with rdata 0xAAAA0001, 0xBBBB0002 -> rvalid_o = 2'b10 then 2'b01, with rdata_o matching.
REQ-038 rvalid with instr_err_pmp_i = 1 for a requester-1 transaction -> err_pmp_o = 2'b10 in that cycle.
REQ-039 rst_n low while 2 transactions are outstanding, then a spurious rvalid -> rvalid_o = 0, busy_o = 0, and the empty-FIFO assertion fires.
